// File: rtl/serial_to_parallel_align_pkg.sv
// Shared definitions for the serial receive aligner.
// The transmit-side serializer uses the same state codes and comma character.
package serial_to_parallel_align_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } sp_state_t;

    localparam logic [7:0] SP_COMMA_DEFAULT = 8'hBC;

    // Comma counter increment that sticks at the sync threshold
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/serial_to_parallel_align_if.sv
// Bus between the serial source and the aligner.
// byte_count exists only when SP_BYTE_COUNT_EN is defined.
interface serial_to_parallel_align_if #(
    parameter int DATA_SIZE = 8
);
    logic                 in_serial;
    logic                 in_valid;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 active;
`ifdef SP_BYTE_COUNT_EN
    logic [15:0]          byte_count;

    modport master (output in_serial, in_valid,
                    input  out_data, out_valid, active, byte_count);
    modport slave  (input  in_serial, in_valid,
                    output out_data, out_valid, active, byte_count);
`else
    modport master (output in_serial, in_valid,
                    input  out_data, out_valid, active);
    modport slave  (input  in_serial, in_valid,
                    output out_data, out_valid, active);
`endif
endinterface

// File: rtl/serial_to_parallel_align_shift_reg.sv
// Serial shift register and bit counter; nxt is the byte that includes the current bit.
// Only DATA_SIZE-1 history bits are stored since the oldest bit falls out of nxt.
module sp_shift_reg #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift_en,
    input  logic                 cnt_clr,
    input  logic                 bit_in,
    output logic [DATA_SIZE-1:0] nxt,
    output logic                 wrap
);
    localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);

    logic [DATA_SIZE-2:0] shift_reg;
    logic [CW-1:0]        bit_cnt_reg;

    assign nxt[0] = bit_in;
    generate
        for (genvar gi = 0; gi < DATA_SIZE - 1; gi++) begin : g_nxt
            assign nxt[gi+1] = shift_reg[gi];
        end
    endgenerate

    assign wrap = (bit_cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= nxt[DATA_SIZE-2:0];
            if (cnt_clr || wrap) begin
                bit_cnt_reg <= '0;
            end else begin
                bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel_align.sv
// Comma-aligned serial-to-parallel receiver with sync qualification.
// Optional byte counter output enabled by SP_BYTE_COUNT_EN.
module serial_to_parallel_align
    import serial_to_parallel_align_pkg::*;
#(
    parameter int                   DATA_SIZE  = 8,
    parameter logic [DATA_SIZE-1:0] COMMA      = DATA_SIZE'(SP_COMMA_DEFAULT),
    parameter int                   SYNC_COUNT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    serial_to_parallel_align_if.slave   bus
);
    localparam logic [3:0] SYNC_LIM = 4'(SYNC_COUNT);

    sp_state_t            state_reg;
    logic [3:0]           comma_cnt_reg;
    logic [DATA_SIZE-1:0] out_data_reg;
    logic                 out_valid_reg;
    logic                 active_reg;
    logic [DATA_SIZE-1:0] nxt;
    logic                 wrap;
    logic                 is_comma;

    // Bit counter is pinned at 0 while hunting so the first comma sets the boundary
    sp_shift_reg #(.DATA_SIZE(DATA_SIZE)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .shift_en (bus.in_valid),
        .cnt_clr  (state_reg == SEARCH),
        .bit_in   (bus.in_serial),
        .nxt      (nxt),
        .wrap     (wrap)
    );

    assign is_comma = (nxt == COMMA);

`ifdef SP_BYTE_COUNT_EN
    logic [15:0] byte_count_reg;
    assign bus.byte_count = byte_count_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SEARCH;
            comma_cnt_reg <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            active_reg    <= 1'b0;
`ifdef SP_BYTE_COUNT_EN
            byte_count_reg <= '0;
`endif
        end else begin
            out_valid_reg <= 1'b0;
            if (bus.in_valid) begin
                case (state_reg)
                    SEARCH: begin
                        if (is_comma) begin
                            comma_cnt_reg <= 4'd1;
                            if (SYNC_LIM == 4'd1) begin
                                state_reg  <= ACTIVE;
                                active_reg <= 1'b1;
                            end else begin
                                state_reg <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        if (wrap) begin
                            if (is_comma) begin
                                comma_cnt_reg <= sat_inc(comma_cnt_reg, SYNC_LIM);
                                if (sat_inc(comma_cnt_reg, SYNC_LIM) == SYNC_LIM) begin
                                    state_reg  <= ACTIVE;
                                    active_reg <= 1'b1;
                                end
                            end else begin
                                comma_cnt_reg <= '0;
                                state_reg     <= SEARCH;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (wrap && !is_comma) begin
                            out_data_reg  <= nxt;
                            out_valid_reg <= 1'b1;
`ifdef SP_BYTE_COUNT_EN
                            byte_count_reg <= byte_count_reg + 16'd1;
`endif
                        end
                    end
                    default: begin
                        state_reg <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.active    = active_reg;

endmodule

// File: doc/serial_to_parallel_align.md
Name: serial_to_parallel_align

Overview:
- Receive-side stage directly downstream of the parallel-to-serial converter.
- Consumes one serial bit stream, MSB first, one bit per clk cycle when in_valid is high.
- Finds byte alignment on the comma character, then qualifies sync after SYNC_COUNT consecutive aligned commas.
- Once synced, presents each received data byte in parallel with a one-cycle valid strobe; idle commas are dropped.

Parameters:
- DATA_SIZE, 8, width of one recovered byte.
- COMMA, 8'hBC, alignment/idle character.
- SYNC_COUNT, 4, consecutive aligned commas required to enter ACTIVE (range 1..15).

Ports:
- clk  input  1  serial bit clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_serial  input  1  serial data bit, MSB of each byte first.
- in_valid  input  1  in_serial is sampled only when high; when low, all state holds.
- out_data  output  DATA_SIZE  recovered byte, registered.
- out_valid  output  1  one-cycle strobe: out_data holds a new non-comma byte.
- active  output  1  high while in ACTIVE state (link synced).

Behaviour:
- Reset (reset=1 at an edge), regardless of current state:
  - state=SEARCH, shift register=0, bit_cnt=0, comma_cnt=0.
  - out_data=0, out_valid=0, active=0.
  - Same effect when asserted mid-byte or in ACTIVE; the partial byte is discarded.
- Byte assembly: nxt = {shift[DATA_SIZE-2:0], in_serial}, evaluated on each edge with in_valid=1. Edges with in_valid=0 change nothing, and out_valid drops to 0.
- SEARCH:
  - Shift every valid bit.
  - If nxt==COMMA: bit_cnt=0, comma_cnt=1. Go to COUNT, or directly to ACTIVE if SYNC_COUNT==1.
- COUNT:
  - bit_cnt increments per valid bit and wraps DATA_SIZE-1 -> 0.
  - At the wrap edge (byte boundary), evaluate nxt:
    - COMMA: comma_cnt+1. When the new value equals SYNC_COUNT, go to ACTIVE.
    - Anything else: comma_cnt=0, back to SEARCH. Realignment starts from the next bit.
- ACTIVE:
  - active=1, with the same byte-boundary counting.
  - At the boundary, if nxt!=COMMA: out_data<=nxt, out_valid<=1 for exactly one cycle.
  - If nxt==COMMA: out_valid<=0 and out_data holds.
  - ACTIVE is left only by reset.
- Latency: out_valid is high in the cycle immediately after the edge sampling the byte's last bit.
- Throughput: at most one out_valid per DATA_SIZE valid bits; out_valid is never high on two consecutive cycles.
- Counters: comma_cnt is 4 bits and saturates at SYNC_COUNT. bit_cnt is clog2(DATA_SIZE) bits.
- Boundaries:
  - A comma pattern straddling the old alignment in COUNT/ACTIVE is ignored; only boundary bytes are checked.
  - A gap in in_valid mid-byte does not break alignment.

Optional Feature:
- Macro: SP_BYTE_COUNT_EN.
- Defined: adds output byte_count [15:0].
  - Reset to 0; increments on every out_valid; wraps 16'hFFFF -> 0.
  - Holds outside ACTIVE.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package/include: state encoding constants (SEARCH=2'd0, COUNT=2'd1, ACTIVE=2'd2) and the default COMMA value 8'hBC, shared with the transmit-side serializer.
- Natural sub-module: sp_shift_reg (DATA_SIZE shift register plus bit_cnt with wrap flag). The FSM and output registers remain in the top.

Test Plan:
- Reset mid-byte in ACTIVE -> next cycle active=0, out_valid=0, out_data=0. Re-sync needs SYNC_COUNT fresh commas.
- 3 garbage bits, then 4×8'hBC, then 8'hA5 -> active=1 after the 4th comma's last bit; out_valid=1 with out_data=8'hA5 one cycle after its last bit.
- 3×8'hBC then 8'h3C -> returns to SEARCH, active stays 0, no out_valid. Then 4×8'hBC -> active=1.
- ACTIVE, stream 8'h11, 8'hBC, 8'h22 -> exactly two strobes, with data 8'h11 then 8'h22. Comma dropped; out_data holds 8'h11 during the comma.
- ACTIVE, send 8'h5A with in_valid low for 5 cycles after bit 3 -> single strobe with 8'h5A; alignment kept for the following byte.
- SP_BYTE_COUNT_EN build: 3 data bytes after sync -> byte_count=3. Preload 16'hFFFF via force, one byte -> 0.
